fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of HOLY CORE, directly upstream of the control unit and decoder. It owns the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel, buffers returned words with their PCs, and presents them to decode with a valid/ready handshake. Taken-branch and jump redirects from the execute side flush the buffer and discard stale in-flight responses.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, default 2: instruction buffer entries; also caps outstanding plus buffered fetches. Power of two, ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: word-aligned fetch address, bits [1:0] always 0.
- `imem_rsp_valid` in 1: response word valid. Always accepted; no ready.
- `imem_rsp_data` in 32: instruction word.
- `dec_valid` out 1: buffer head valid.
- `dec_ready` in 1: decode consumes head.
- `dec_instr` out 32: head instruction.
- `dec_pc` out 32: head PC.
- `dec_misaligned` out 1: head carries a misaligned-target fault. Tied 0 without the macro.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_target` in 32: new PC.

## Operation
- State: `fetch_pc`, `rsp_pc` (PC of the next kept response), `outstanding` and `drop_cnt` counters, FIFO of {instr, pc, misaligned}, FSM {RUN, FAULT}.
- `pop` = `dec_valid & dec_ready`.
- `imem_req_valid` = RUN & ~`redirect_valid` & (`outstanding` + `count` − `pop`) < `BUF_DEPTH`. Requests may be withdrawn; memory must not rely on valid stability.
- On accept (`imem_req_valid & imem_req_ready`): `fetch_pc += 4`, `outstanding++`.
- On response: `outstanding--`.
  - If `drop_cnt` > 0: discard the word, `drop_cnt--`.
  - Otherwise: push {data, `rsp_pc`, 0} and `rsp_pc += 4`.
  - Responses never overflow the FIFO, guaranteed by the credit rule above.
- Redirect, cycle N:
  - Pop in cycle N completes normally; all other entries are flushed.
  - A response arriving in N is discarded.
  - `drop_cnt` ← `outstanding` − `imem_rsp_valid`.
  - `fetch_pc` and `rsp_pc` ← target.
  - New requests may issue from N+1 while drops are still pending.
- FSM:
  - RUN → FAULT on a misaligned redirect (macro only).
  - FAULT → RUN on any aligned redirect.
  - A misaligned redirect while in FAULT stays in FAULT and pushes a fresh fault entry.
- Addresses wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset values: `imem_req_valid`=0, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, `dec_misaligned`=0, `fetch_pc`=`rsp_pc`=`RESET_VECTOR`, counters 0, FSM RUN, FIFO empty.
- First request appears in the first cycle after `rst_n` deasserts, with `imem_req_addr`=`RESET_VECTOR`.
- Reset mid-operation restores all reset values. Responses to pre-reset requests are the memory's responsibility to suppress.
- No bypass: a response in cycle T is visible on `dec_*` at T+1.
- Redirect in N → request to the target in N+1. With 1-cycle memory, response in N+2 and `dec_valid` in N+3.
- Throughput is 1 instr/cycle with 1-cycle memory and `BUF_DEPTH`=2, because the credit check counts the same-cycle pop.
- `dec_*` is stable while `dec_valid & ~dec_ready`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with target[1:0]≠0 enters FAULT.
  - Pushes one entry {32'h0000_0013, target, misaligned=1}.
  - Issues no requests until the next redirect.
- Undefined:
  - target[1:0] is forced to 0; the FSM never leaves RUN.
  - `dec_misaligned` is constant 0.

## Test plan
- Reset, memory always ready, 1-cycle latency, words = address → `dec_pc` 0,4,8,… one per cycle starting cycle 3, `dec_instr`==`dec_pc`.
- Hold `dec_ready`=0 for 5 cycles → `outstanding`+`count` ≤ 2, `dec_*` stable. Release → no lost or duplicated PCs.
- Memory with 3-cycle latency, redirect to 32'h100 while 2 requests are outstanding → both stale words dropped, next `dec_pc`=32'h100.
- Redirect in the same cycle as a pop and a response → popped instruction consumed, response discarded, next `dec_pc`=target.
- `fetch_pc` at 32'hFFFF_FFF8 → `imem_req_addr` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Redirect to 32'h102: with macro, one entry {0x13, 0x102, misaligned=1}, then no requests until a redirect to 0x200 resumes fetch. Without macro, fetch resumes at 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: HOLY CORE instruction fetch stage.
//   Owns the fetch PC and issues in-order word requests to instruction memory.
//   Returned words are buffered together with their PCs and handed to decode.
//   A redirect flushes the buffer and discards responses that are still in flight.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   imem_req_*               request channel: valid/ready, word-aligned addr
//   imem_rsp_*               response channel: valid, data (always accepted)
//   dec_*                    decode channel: valid/ready, instr, pc, misaligned flag
//   redirect_valid/_target   flush the buffer and restart fetch at the target
// Build option:
//   FETCH_MISALIGN_TRAP_EN   when defined, a misaligned redirect enters FAULT and
//                            queues one fault entry. When undefined, target[1:0]
//                            is forced to 0 and dec_misaligned is tied 0.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_misaligned,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 1;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef enum logic {RUN, FAULT} state_t;
  state_t r_state, w_state_next;
  logic [31:0] r_fetch_pc, r_rsp_pc;
  logic [CW-1:0] r_out, r_drop, r_count;
  logic [AW-1:0] r_rd, r_wr;
  logic [31:0] r_instr [BUF_DEPTH];
  logic [31:0] r_pc [BUF_DEPTH];
  logic r_mis [BUF_DEPTH];
  logic w_pop, w_acc, w_push, w_mis, w_credit;
  logic [31:0] w_target;
  logic [UW-1:0] w_used;
  assign w_mis = TRAP & (redirect_target[1:0] != 2'b00);
  assign w_target = TRAP ? redirect_target : (redirect_target & ~32'h3);
  assign dec_valid = r_count != '0;
  assign dec_instr = dec_valid ? r_instr[r_rd] : 32'h0;
  assign dec_pc = dec_valid ? r_pc[r_rd] : 32'h0;
  assign dec_misaligned = TRAP & dec_valid & r_mis[r_rd];
  assign w_pop = dec_valid & dec_ready;
  // the same-cycle pop frees a slot, which keeps a depth-2 buffer at full rate
  assign w_used = UW'(r_out) + UW'(r_count) - UW'(w_pop);
  assign w_credit = w_used < UW'(BUF_DEPTH);
  assign imem_req_valid = rst_n & (r_state == RUN) & ~redirect_valid & w_credit;
  assign imem_req_addr = r_fetch_pc & ~32'h3;
  assign w_acc = imem_req_valid & imem_req_ready;
  assign w_push = imem_rsp_valid & (r_drop == '0) & ~redirect_valid;
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) w_state_next = w_mis ? FAULT : RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_fetch_pc <= RESET_VECTOR;
      r_rsp_pc <= RESET_VECTOR;
      r_out <= '0;
      r_drop <= '0;
      r_count <= '0;
      r_rd <= '0;
      r_wr <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        // every response still owed by memory belongs to the old stream
        r_fetch_pc <= w_target;
        r_rsp_pc <= w_target;
        r_out <= r_out - CW'(imem_rsp_valid);
        r_drop <= r_out - CW'(imem_rsp_valid);
        r_rd <= '0;
        r_wr <= AW'(w_mis);
        r_count <= CW'(w_mis);
        if (w_mis) begin
          r_instr[0] <= 32'h0000_0013;
          r_pc[0] <= redirect_target;
          r_mis[0] <= 1'b1;
        end
      end else begin
        if (w_acc) r_fetch_pc <= r_fetch_pc + 32'd4;
        r_out <= r_out + CW'(w_acc) - CW'(imem_rsp_valid);
        if (imem_rsp_valid && r_drop != '0) r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_instr[r_wr] <= imem_rsp_data;
          r_pc[r_wr] <= r_rsp_pc;
          r_mis[r_wr] <= 1'b0;
          r_rsp_pc <= r_rsp_pc + 32'd4;
          r_wr <= r_wr + AW'(1);
        end
        if (w_pop) r_rd <= r_rd + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-configurable memory model.
module tb_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_ready = 1'b1, imem_rsp_valid = 1'b0, dec_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0, redirect_target = 32'h0;
  logic imem_req_valid, dec_valid, dec_misaligned;
  logic [31:0] imem_req_addr, dec_instr, dec_pc;
  int n_cmp = 0, n_err = 0;
  logic pv [4];
  logic [31:0] pa [4];
  int lat = 1;
  logic [31:0] exp_pc = 32'h0;
  logic sb = 1'b0;
  logic [31:0] wrap_seq [3];
  int w;
  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_misaligned(dec_misaligned),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic tick();
    logic a;
    logic [31:0] ad;
    #1;
    a = imem_req_valid & imem_req_ready;
    ad = imem_req_addr;
    if (sb && dec_valid && dec_ready) begin
      chk("pop_pc", dec_pc, exp_pc);
      chk("pop_instr", dec_instr, exp_pc);
      chk("pop_mis", {31'b0, dec_misaligned}, 32'h0);
      exp_pc += 32'd4;
    end
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = a;
    pa[0] = ad;
    imem_rsp_valid = pv[lat-1];
    imem_rsp_data = pa[lat-1];
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pa[i] = 32'h0;
    end
    wrap_seq[0] = 32'hFFFF_FFF8;
    wrap_seq[1] = 32'hFFFF_FFFC;
    wrap_seq[2] = 32'h0000_0000;
    tick();
    tick();
    #1;
    chk("rst_req_v", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_dec_v", {31'b0, dec_valid}, 32'h0);
    chk("rst_instr", dec_instr, 32'h0);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_mis", {31'b0, dec_misaligned}, 32'h0);
    rst_n = 1'b1;
    dec_ready = 1'b1;
    exp_pc = 32'h0;
    sb = 1'b1;
    #1;
    chk("first_req_v", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick();
    #1;
    chk("c2_dec_v", {31'b0, dec_valid}, 32'h0);
    tick();
    repeat (8) begin
      #1;
      chk("stream_v", {31'b0, dec_valid}, 32'h1);
      tick();
    end
    chk("stream_count", exp_pc, 32'h20);
    dec_ready = 1'b0;
    repeat (5) begin
      #1;
      chk("stall_v", {31'b0, dec_valid}, 32'h1);
      chk("stall_pc", dec_pc, exp_pc);
      chk("stall_instr", dec_instr, exp_pc);
      chk("stall_req", {31'b0, imem_req_valid}, 32'h0);
      tick();
    end
    dec_ready = 1'b1;
    repeat (6) begin
      #1;
      chk("release_v", {31'b0, dec_valid}, 32'h1);
      tick();
    end
    chk("release_count", exp_pc, 32'h38);
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    #1;
    chk("redir_pop_v", {31'b0, dec_valid}, 32'h1);
    chk("redir_rsp_v", {31'b0, imem_rsp_valid}, 32'h1);
    chk("redir_req_v", {31'b0, imem_req_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    chk("redir_popped", exp_pc, 32'h3C);
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wrap_req_v", {31'b0, imem_req_valid}, 32'h1);
      chk("wrap_addr", imem_req_addr, wrap_seq[i]);
      chk("wrap_dec_v", {31'b0, dec_valid}, (i == 2) ? 32'h1 : 32'h0);
      tick();
    end
    repeat (3) tick();
    chk("wrap_count", exp_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    sb = 1'b0;
    #1;
    chk("fault_v", {31'b0, dec_valid}, 32'h1);
    chk("fault_pc", dec_pc, 32'h102);
    chk("fault_instr", dec_instr, 32'h13);
    chk("fault_mis", {31'b0, dec_misaligned}, 32'h1);
    chk("fault_req", {31'b0, imem_req_valid}, 32'h0);
    tick();
    repeat (3) begin
      #1;
      chk("fault_idle_req", {31'b0, imem_req_valid}, 32'h0);
      chk("fault_idle_v", {31'b0, dec_valid}, 32'h0);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    exp_pc = 32'h200;
    sb = 1'b1;
    #1;
    chk("resume_req_v", {31'b0, imem_req_valid}, 32'h1);
    chk("resume_addr", imem_req_addr, 32'h200);
    tick();
    repeat (4) tick();
    chk("resume_count", exp_pc, 32'h20C);
`else
    exp_pc = 32'h100;
    #1;
    chk("misal_req_v", {31'b0, imem_req_valid}, 32'h1);
    chk("misal_addr", imem_req_addr, 32'h100);
    chk("misal_flag", {31'b0, dec_misaligned}, 32'h0);
    tick();
    repeat (4) tick();
    chk("misal_count", exp_pc, 32'h10C);
`endif
    sb = 1'b0;
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    imem_rsp_valid = 1'b0;
    lat = 3;
    #1;
    chk("mid_rst_dec_v", {31'b0, dec_valid}, 32'h0);
    chk("mid_rst_req_v", {31'b0, imem_req_valid}, 32'h0);
    chk("mid_rst_pc", dec_pc, 32'h0);
    rst_n = 1'b1;
    exp_pc = 32'h0;
    sb = 1'b1;
    #1;
    chk("lat3_c1_addr", imem_req_addr, 32'h0);
    tick();
    #1;
    chk("lat3_c2_addr", imem_req_addr, 32'h4);
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    exp_pc = 32'h100;
    #1;
    chk("lat3_c4_req", {31'b0, imem_req_valid}, 32'h0);
    chk("lat3_c4_rsp", {31'b0, imem_rsp_valid}, 32'h1);
    tick();
    #1;
    chk("lat3_c5_req", {31'b0, imem_req_valid}, 32'h1);
    chk("lat3_c5_addr", imem_req_addr, 32'h100);
    tick();
    w = 0;
    #1;
    while (!dec_valid && w < 20) begin
      tick();
      #1;
      w++;
    end
    chk("lat3_wait", w, 3);
    repeat (6) tick();
    chk("lat3_count", exp_pc, 32'h110);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
